// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with one-cycle memory latency, a one-entry
// skid buffer that catches the response landing during a stall, and
// redirect-driven flush.
module fetch_stage #(
  parameter logic [31:0] NOP = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_idata
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] data;
  } ifid_t;

  localparam ifid_t BUBBLE = '{valid: 1'b0, pc: 32'h0, data: NOP};

  logic [31:0] pc_q, req_pc_q;
  logic        inflight_q;
  logic        buf_valid_q;
  logic [31:0] buf_pc_q, buf_data_q;
  ifid_t       ifid_q, ifid_ld;
  logic        buf_wr;

  // A request goes out whenever nothing holds or flushes the front end.
  always_comb begin
    imem_req  = rst_n && !stall && !redirect;
    imem_addr = pc_q;
  end

  // Next IF/ID contents on an unstalled cycle: the buffered instruction is
  // older than anything in flight, so it drains first.
  always_comb begin
    ifid_ld = BUBBLE;
    if (buf_valid_q)
      ifid_ld = '{valid: 1'b1, pc: buf_pc_q, data: buf_data_q};
    else if (inflight_q)
      ifid_ld = '{valid: 1'b1, pc: req_pc_q, data: imem_rdata};
  end

  // The response of a request issued just before a stall must be parked.
  assign buf_wr = stall && !redirect && inflight_q;

  // PC, request tracking, skid buffer and IF/ID register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= 32'h0;
      req_pc_q    <= 32'h0;
      inflight_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= 32'h0;
      buf_data_q  <= 32'h0;
      ifid_q      <= BUBBLE;
    end else if (redirect) begin
      // low address bits are dropped; in-flight data is simply never used
      pc_q        <= redirect_pc & ~32'h3;
      inflight_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      ifid_q      <= BUBBLE;
    end else if (stall) begin
      inflight_q <= 1'b0;
      if (buf_wr) begin
        buf_valid_q <= 1'b1;
        buf_pc_q    <= req_pc_q;
        buf_data_q  <= imem_rdata;
      end
    end else begin
      pc_q        <= pc_q + 32'd4;
      req_pc_q    <= pc_q;
      inflight_q  <= 1'b1;
      buf_valid_q <= 1'b0;
      ifid_q      <= ifid_ld;
    end
  end

  always_comb begin
    if_valid = ifid_q.valid;
    if_pc    = ifid_q.pc;
    if_idata = ifid_q.data;
  end

  // A stalled cycle issues no request, so at most one response is ever
  // parked; a second write would overwrite an undelivered instruction.
  skid_no_overwrite: assert property (@(posedge clk) disable iff (!rst_n)
    buf_wr |-> !buf_valid_q);

endmodule
